// File: rtl/nibbler_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : nibbler_sequencer
//  Purpose  : Fetch/execute control unit for the Nibbler 4-bit CPU. Latches
//             each ROM word, decodes the opcode and drives one-cycle strobes
//             to the PC, accumulator, ALU, FLAGS, data memory and I/O ports.
//             A run/step control allows free-running or single-stepping.
//  Ports    : clk, reset (async, active-high)
//             instr[7:0]    ROM word ([7:4] opcode, [3:0] operand)
//             ready         low stalls the current phase
//             flagsOut[1:0] stored active-low flags {notC, notZ}
//             run, step     debug control (level / single pulse)
//             opcode, operand   registered instruction fields
//             phase, halted     0=FETCH/1=EXEC, 1 while IDLE
//             incPC, loadPC, loadA, loadFlags, aluOp, selB,
//             memRead, memWrite, inRead, outWrite   datapath controls
//  Revision : 1.0  initial release
// ============================================================================
module nibbler_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       ready,
    input  logic [1:0] flagsOut,
    input  logic       run,
    input  logic       step,
    output logic [3:0] opcode,
    output logic [3:0] operand,
    output logic       phase,
    output logic       halted,
    output logic       incPC,
    output logic       loadPC,
    output logic       loadA,
    output logic       loadFlags,
    output logic [1:0] aluOp,
    output logic       selB,
    output logic       memRead,
    output logic       memWrite,
    output logic       inRead,
    output logic       outWrite
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0] c_ALU_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_SUB  = 2'b01;
    localparam logic [1:0] c_ALU_NOR  = 2'b10;
    localparam logic [1:0] c_ALU_PASS = 2'b11;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_step_pending;
    logic       w_step_pending_next;
    logic [3:0] r_opcode;
    logic [3:0] r_operand;
    logic       w_take;

    // ------------------------------------------------------------------
    // State, step tracking and instruction latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_step_pending <= 1'b0;
            r_opcode       <= 4'd0;
            r_operand      <= 4'd0;
        end else begin
            r_state        <= w_state_next;
            r_step_pending <= w_step_pending_next;
            if (r_state == ST_FETCH && ready) begin
                r_opcode  <= instr[7:4];
                r_operand <= instr[3:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next        = r_state;
        w_step_pending_next = r_step_pending;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    // run overrides a simultaneous step
                    w_state_next        = ST_FETCH;
                    w_step_pending_next = 1'b0;
                end else if (step && !r_step_pending) begin
                    w_state_next        = ST_FETCH;
                    w_step_pending_next = 1'b1;
                end
            end
            ST_FETCH: begin
                if (ready)
                    w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (ready) begin
                    if (run) begin
                        w_state_next = ST_FETCH;
                    end else begin
                        // run dropped or a single step finished
                        w_state_next        = ST_IDLE;
                        w_step_pending_next = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next        = ST_IDLE;
                w_step_pending_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decode / strobe generation (Moore on state + registered opcode,
    // qualified by ready)
    // ------------------------------------------------------------------
    always_comb begin
        halted    = (r_state == ST_IDLE);
        phase     = (r_state == ST_EXEC);
        incPC     = (r_state == ST_FETCH) && ready;
        loadPC    = 1'b0;
        loadA     = 1'b0;
        loadFlags = 1'b0;
        aluOp     = c_ALU_ADD;
        selB      = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        inRead    = 1'b0;
        outWrite  = 1'b0;
        w_take    = 1'b0;

        if (r_state == ST_EXEC) begin
            case (r_opcode)
                4'h0: w_take = ~flagsOut[1];   // JC : carry set (notC=0)
                4'h1: w_take =  flagsOut[1];   // JNC
                4'h2: w_take = ~flagsOut[0];   // JZ : zero set (notZ=0)
                4'h3: w_take =  flagsOut[0];   // JNZ
                4'h4: w_take = 1'b1;           // JMP
                4'h5: begin loadA = 1'b1; aluOp = c_ALU_PASS; end
                4'h6: begin loadA = 1'b1; loadFlags = 1'b1; aluOp = c_ALU_ADD; end
                4'h7: begin
                    loadA = 1'b1; loadFlags = 1'b1; aluOp = c_ALU_ADD;
                    selB  = 1'b1; memRead = 1'b1;
                end
                4'h8: begin loadFlags = 1'b1; aluOp = c_ALU_SUB; end
                4'h9: begin
                    loadFlags = 1'b1; aluOp = c_ALU_SUB;
                    selB      = 1'b1; memRead = 1'b1;
                end
                4'hA: begin loadA = 1'b1; loadFlags = 1'b1; aluOp = c_ALU_NOR; end
                4'hB: begin
                    loadA = 1'b1; loadFlags = 1'b1; aluOp = c_ALU_NOR;
                    selB  = 1'b1; memRead = 1'b1;
                end
                4'hC: begin
                    loadA = 1'b1; aluOp = c_ALU_PASS;
                    selB  = 1'b1; memRead = 1'b1;
                end
                4'hD: memWrite = 1'b1;
                4'hE: begin loadA = 1'b1; aluOp = c_ALU_PASS; inRead = 1'b1; end
                4'hF: outWrite = 1'b1;
                default: ;
            endcase
            loadPC = w_take;

            // During a stall the datapath source selection stays up so the
            // bus settles, but nothing is allowed to capture or side-effect.
            if (!ready) begin
                loadPC    = 1'b0;
                loadA     = 1'b0;
                loadFlags = 1'b0;
                memWrite  = 1'b0;
                inRead    = 1'b0;
                outWrite  = 1'b0;
            end
        end
    end

    assign opcode  = r_opcode;
    assign operand = r_operand;

endmodule
`default_nettype wire
